// File: rtl/fetch_mem_arbiter.sv
// Arbiter sharing one single-ported, fixed-latency SRAM between instruction
// fetch (IF) and load/store (MEM). Each access is IDLE -> BUSY (WAIT_CYCLES+1
// cycles) -> RESP (one-cycle ready pulse). MEM wins ties unless IF has lost
// MAX_STARVE consecutive ties, in which case IF wins the next one.
module fetch_mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 2,
    parameter int MAX_STARVE  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_inst,
    output logic              if_ready,
    output logic              if_freeze,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic              mem_freeze,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic              busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int               CNT_W    = $clog2(WAIT_CYCLES + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);
    localparam int               STV_W    = $clog2(MAX_STARVE + 2);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(MAX_STARVE);
    localparam bit               STV_EN   = (MAX_STARVE != 0);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [STV_W-1:0]  r_starve;
    logic              r_win_mem;   // latched winner: 1 = MEM, 0 = IF
    logic              r_mem_load;  // MEM winner is a pure load (rdata captured)
    logic              r_sram_en;
    logic              r_sram_we;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [31:0]       r_sram_wdata;
    logic [31:0]       r_if_inst;
    logic [31:0]       r_mem_rdata;
    logic              r_if_ready;
    logic              r_mem_ready;
    logic              r_busy;

    logic w_if_act;
    logic w_mem_act;
    logic w_both;
    logic w_grant_if;
    logic w_unused_addr_bits;

    assign w_if_act   = if_req;
    assign w_mem_act  = mem_rd | mem_wr;
    assign w_both     = w_if_act & w_mem_act;
    // IF wins when alone, or on a tie once it has been starved long enough
    assign w_grant_if = w_if_act & (~w_mem_act | (STV_EN && (r_starve == STV_MAX)));

    // Byte-offset and out-of-range address bits never reach the SRAM
    assign w_unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                  mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    // Access sequencer: grant and latch in IDLE, count wait states, pulse ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_starve     <= '0;
            r_win_mem    <= 1'b0;
            r_mem_load   <= 1'b0;
            r_sram_en    <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_if_inst    <= '0;
            r_mem_rdata  <= '0;
            r_if_ready   <= 1'b0;
            r_mem_ready  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_if_act | w_mem_act) begin
                        r_state      <= S_BUSY;
                        r_busy       <= 1'b1;
                        r_sram_en    <= 1'b1;
                        r_cnt        <= '0;
                        r_win_mem    <= ~w_grant_if;
                        r_sram_addr  <= w_grant_if ? if_addr[ADDR_W+1:2] : mem_addr[ADDR_W+1:2];
                        r_sram_we    <= ~w_grant_if & mem_wr;
                        r_sram_wdata <= mem_wdata;
                        // A simultaneous rd+wr is treated as a store only
                        r_mem_load   <= ~w_grant_if & mem_rd & ~mem_wr;
                        if (w_grant_if) begin
                            r_starve <= '0;
                        end else if (w_both && (r_starve != STV_MAX)) begin
                            r_starve <= r_starve + 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        if (!r_win_mem) begin
                            r_if_inst <= sram_rdata;
                        end else if (r_mem_load) begin
                            r_mem_rdata <= sram_rdata;
                        end
                        r_state     <= S_RESP;
                        r_sram_en   <= 1'b0;
                        r_sram_we   <= 1'b0;
                        r_if_ready  <= ~r_win_mem;
                        r_mem_ready <= r_win_mem;
                    end
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_if_ready  <= 1'b0;
                    r_mem_ready <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_sram_en   <= 1'b0;
                    r_sram_we   <= 1'b0;
                    r_if_ready  <= 1'b0;
                    r_mem_ready <= 1'b0;
                end
            endcase
        end
    end

    assign sram_en    = r_sram_en;
    assign sram_we    = r_sram_we;
    assign sram_addr  = r_sram_addr;
    assign sram_wdata = r_sram_wdata;
    assign if_inst    = r_if_inst;
    assign mem_rdata  = r_mem_rdata;
    assign if_ready   = r_if_ready;
    assign mem_ready  = r_mem_ready;
    assign busy       = r_busy;
    assign if_freeze  = if_req & ~r_if_ready;
    assign mem_freeze = (mem_rd | mem_wr) & ~r_mem_ready;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Bench for fetch_mem_arbiter: directed scenarios with literal expectations,
// then random IF/MEM traffic checked every cycle against a schedule-level model.
`timescale 1ns/1ps
module tb_fetch_mem_arbiter;
    localparam int W  = 2;
    localparam int MS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (WAIT_CYCLES=2, MAX_STARVE=4)
    logic        rst, if_req, mem_rd, mem_wr;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [31:0] if_inst, mem_rdata, sram_wdata, sram_rdata;
    logic        if_ready, if_freeze, mem_ready, mem_freeze, sram_en, sram_we, busy;
    logic [15:0] sram_addr;

    fetch_mem_arbiter #(.ADDR_W(16), .WAIT_CYCLES(W), .MAX_STARVE(MS)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst),
        .if_ready(if_ready), .if_freeze(if_freeze),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_freeze(mem_freeze),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy)
    );

    // Second instance: zero wait states, strict MEM priority
    logic        z_if_req, z_mem_rd, z_mem_wr;
    logic [31:0] z_if_addr, z_mem_addr, z_mem_wdata;
    logic [31:0] z_if_inst, z_mem_rdata, z_sram_rdata, unused_z_wdata;
    logic        z_if_ready, z_if_freeze, z_mem_ready, unused_z_mem_freeze;
    logic        z_sram_en, z_sram_we, z_busy;
    logic [15:0] z_sram_addr;

    fetch_mem_arbiter #(.ADDR_W(16), .WAIT_CYCLES(0), .MAX_STARVE(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .if_req(z_if_req), .if_addr(z_if_addr), .if_inst(z_if_inst),
        .if_ready(z_if_ready), .if_freeze(z_if_freeze),
        .mem_rd(z_mem_rd), .mem_wr(z_mem_wr), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
        .mem_rdata(z_mem_rdata), .mem_ready(z_mem_ready), .mem_freeze(unused_z_mem_freeze),
        .sram_en(z_sram_en), .sram_we(z_sram_we), .sram_addr(z_sram_addr),
        .sram_wdata(unused_z_wdata), .sram_rdata(z_sram_rdata), .busy(z_busy)
    );
    assign z_sram_rdata = {16'hA5A5, z_sram_addr};

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hE3A01005;
        return 32'h5A00_0000 ^ (32'(i) * 32'h9E37_79B9);
    endfunction

    // SRAM behaviour: data visible combinationally while enabled, writes on edges
    logic [31:0] sram_mem [0:255];
    assign sram_rdata = sram_en ? sram_mem[sram_addr[7:0]] : 32'h0;
    initial begin
        for (int i = 0; i < 256; i++) sram_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (sram_en && sram_we) sram_mem[sram_addr[7:0]] <= sram_wdata;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%b expected=%b", nm, $time, act, exp);
        end
    endtask

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    // ---------------- Schedule-level reference model ----------------
    // An access granted in cycle c occupies the SRAM in cycles c+1..c+1+W and
    // reports ready in cycle c+2+W; the arbiter is free again after that.
    int          cyc = 0;
    bit          acc_v, acc_mem, acc_we, acc_load;
    int          acc_s;
    logic [15:0] acc_addr;
    logic [31:0] acc_wdata, acc_data, e_if_inst, e_mem_rdata;
    int          starve;
    logic [31:0] ref_mem [0:255];
    bit          in_busy, in_resp, m_act, give_if;
    int          n_txn = 0;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        acc_v = 0; starve = 0; e_if_inst = '0; e_mem_rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                acc_v = 0; starve = 0; e_if_inst = '0; e_mem_rdata = '0;
            end
            in_busy = acc_v && (cyc >= acc_s) && (cyc <= acc_s + W);
            in_resp = acc_v && (cyc == acc_s + W + 1);
            if (in_resp) begin
                if (!acc_mem) e_if_inst = acc_data;
                else if (acc_load) e_mem_rdata = acc_data;
                n_txn++;
                $display("txn %0d: %s addr=0x%h data=0x%h", n_txn,
                         !acc_mem ? "IF-FETCH" : (acc_we ? "MEM-STORE" : "MEM-LOAD"),
                         acc_addr, acc_we ? acc_wdata : acc_data);
            end
            check1("m_sram_en", sram_en, in_busy);
            check1("m_sram_we", sram_we, in_busy && acc_we);
            if (in_busy) check32("m_sram_addr", {16'h0, sram_addr}, {16'h0, acc_addr});
            if (in_busy && acc_we) check32("m_sram_wdata", sram_wdata, acc_wdata);
            if (!rst) begin
                check32("m_rst_addr", {16'h0, sram_addr}, 32'h0);
                check32("m_rst_wdata", sram_wdata, 32'h0);
            end
            check1("m_if_ready", if_ready, in_resp && !acc_mem);
            check1("m_mem_ready", mem_ready, in_resp && acc_mem);
            check1("m_busy", busy, in_busy || in_resp);
            check32("m_if_inst", if_inst, e_if_inst);
            check32("m_mem_rdata", mem_rdata, e_mem_rdata);
            check1("m_if_freeze", if_freeze, if_req && !(in_resp && !acc_mem));
            check1("m_mem_freeze", mem_freeze, (mem_rd || mem_wr) && !(in_resp && acc_mem));
            // Arbitration decision for this idle cycle
            m_act = mem_rd || mem_wr;
            if (rst && !in_busy && !in_resp && (if_req || m_act)) begin
                give_if = if_req && (!m_act || (MS != 0 && starve == MS));
                if (give_if) starve = 0;
                else if (if_req && starve < MS) starve++;
                acc_v = 1; acc_s = cyc + 1; acc_mem = !give_if;
                if (give_if) begin
                    acc_addr = if_addr[17:2]; acc_we = 0; acc_load = 0;
                    acc_wdata = '0; acc_data = ref_mem[if_addr[9:2]];
                end else begin
                    acc_addr = mem_addr[17:2]; acc_we = mem_wr; acc_load = mem_rd && !mem_wr;
                    acc_wdata = mem_wdata; acc_data = ref_mem[mem_addr[9:2]];
                    if (mem_wr) ref_mem[mem_addr[9:2]] = mem_wdata;
                end
            end
        end
    end

    // ---------------- Stimulus ----------------
    task automatic drive_edge();
        @(posedge clk);
        #2;
    endtask

    logic si, sm, seen;
    int   k;

    initial begin
        rst = 1'b0; if_req = 0; if_addr = '0; mem_rd = 0; mem_wr = 0; mem_addr = '0; mem_wdata = '0;
        z_if_req = 0; z_if_addr = '0; z_mem_rd = 0; z_mem_wr = 0; z_mem_addr = '0; z_mem_wdata = '0;
        repeat (3) @(negedge clk);
        check1("rst_sram_en", sram_en, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check32("rst_if_inst", if_inst, 32'h0);
        check1("rst_z_busy", z_busy, 1'b0);
        drive_edge(); rst = 1'b1;
        @(negedge clk);
        check1("post_rst_busy", busy, 1'b0);
        check1("post_rst_if_ready", if_ready, 1'b0);

        // IF fetch of 0x10 -> word 4
        drive_edge(); if_req = 1; if_addr = 32'h10;
        @(negedge clk);
        check1("if_c0_freeze", if_freeze, 1'b1);
        check1("if_c0_en", sram_en, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check1("if_busy_en", sram_en, 1'b1);
            check32("if_busy_addr", {16'h0, sram_addr}, 32'd4);
            check1("if_busy_ready", if_ready, 1'b0);
            check1("if_busy_freeze", if_freeze, 1'b1);
        end
        @(negedge clk);
        check1("if_c4_ready", if_ready, 1'b1);
        check32("if_c4_inst", if_inst, 32'hE3A01005);
        check1("if_c4_freeze", if_freeze, 1'b0);
        check1("if_c4_en", sram_en, 1'b0);
        drive_edge(); if_req = 0;

        // MEM store 0xDEADBEEF to 0x20, then IF fetch of 0x20
        drive_edge(); mem_wr = 1; mem_addr = 32'h20; mem_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check1("st_c0_freeze", mem_freeze, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check1("st_we", sram_we, 1'b1);
            check32("st_addr", {16'h0, sram_addr}, 32'd8);
            check32("st_wdata", sram_wdata, 32'hDEADBEEF);
        end
        @(negedge clk);
        check1("st_c4_ready", mem_ready, 1'b1);
        check1("st_c4_we", sram_we, 1'b0);
        drive_edge(); mem_wr = 0; if_req = 1; if_addr = 32'h20;
        repeat (5) @(negedge clk);
        check1("rb_ready", if_ready, 1'b1);
        check32("rb_inst", if_inst, 32'hDEADBEEF);
        drive_edge(); if_req = 0;

        // Tie: MEM served first, IF after
        drive_edge(); if_req = 1; if_addr = 32'h10; mem_rd = 1; mem_addr = 32'h20;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            if (c < 9) check1("tie_if_freeze", if_freeze, 1'b1);
            if (c == 4) begin
                check1("tie_mem_ready", mem_ready, 1'b1);
                check32("tie_mem_rdata", mem_rdata, 32'hDEADBEEF);
                drive_edge(); mem_rd = 0;
            end
            if (c == 9) begin
                check1("tie_if_ready", if_ready, 1'b1);
                check1("tie_mem_ready9", mem_ready, 1'b0);
            end
        end
        drive_edge(); if_req = 0;

        // Starvation bound: both held, MEM wins 4 ties, IF the 5th, MEM the 6th
        drive_edge(); if_req = 1; if_addr = 32'h10; mem_rd = 1; mem_addr = 32'h20;
        for (int c = 0; c <= 29; c++) begin
            @(negedge clk);
            if (c % 5 == 4) begin
                check1("stv_mem_ready", mem_ready, c != 24);
                check1("stv_if_ready", if_ready, c == 24);
            end
        end
        drive_edge(); if_req = 0; mem_rd = 0;

        // Illegal rd+wr: store happens, mem_rdata untouched
        drive_edge(); mem_rd = 1; mem_wr = 1; mem_addr = 32'h30; mem_wdata = 32'h12345678;
        repeat (2) @(negedge clk);
        check1("ill_we", sram_we, 1'b1);
        repeat (3) @(negedge clk);
        check1("ill_ready", mem_ready, 1'b1);
        check32("ill_rdata_kept", mem_rdata, 32'hDEADBEEF);
        drive_edge(); mem_rd = 0; mem_wr = 0; if_req = 1; if_addr = 32'h30;
        repeat (5) @(negedge clk);
        check32("ill_rb_inst", if_inst, 32'h12345678);
        drive_edge(); if_req = 0;

        // Asynchronous reset in the middle of a store
        drive_edge(); mem_wr = 1; mem_addr = 32'h24; mem_wdata = 32'hCAFEF00D;
        repeat (2) @(negedge clk);
        check1("ar_we_before", sram_we, 1'b1);
        @(posedge clk); #3; rst = 1'b0; #1;
        check1("ar_en", sram_en, 1'b0);
        check1("ar_we", sram_we, 1'b0);
        check1("ar_busy", busy, 1'b0);
        drive_edge(); rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (mem_ready) seen = 1;
        end
        check1("ar_recover_ready", seen, 1'b1);
        drive_edge(); mem_wr = 0; if_req = 1; if_addr = 32'h24;
        repeat (5) @(negedge clk);
        check32("ar_rb_inst", if_inst, 32'hCAFEF00D);
        drive_edge(); if_req = 0;

        // Zero wait states: ready two cycles after the request, one SRAM cycle
        drive_edge(); z_if_req = 1; z_if_addr = 32'h40;
        @(negedge clk);
        check1("z_c0_en", z_sram_en, 1'b0);
        check1("z_c0_freeze", z_if_freeze, 1'b1);
        @(negedge clk);
        check1("z_c1_en", z_sram_en, 1'b1);
        check32("z_c1_addr", {16'h0, z_sram_addr}, 32'd16);
        check1("z_c1_we", z_sram_we, 1'b0);
        @(negedge clk);
        check1("z_c2_ready", z_if_ready, 1'b1);
        check32("z_c2_inst", z_if_inst, 32'hA5A50010);
        check1("z_c2_en", z_sram_en, 1'b0);
        drive_edge(); z_if_req = 0;

        // Strict MEM priority when the starvation bound is disabled
        drive_edge(); z_if_req = 1; z_mem_rd = 1; z_mem_addr = 32'h44;
        for (int c = 0; c <= 14; c++) begin
            @(negedge clk);
            if (c % 3 == 2) begin
                check1("z_strict_mem", z_mem_ready, c <= 11);
                check1("z_strict_if", z_if_ready, c == 14);
            end
            if (c == 2) check32("z_mem_rdata", z_mem_rdata, 32'hA5A50011);
            if (c == 11) begin
                drive_edge(); z_mem_rd = 0;
            end
        end
        drive_edge(); z_if_req = 0;

        // Random traffic; requesters hold until ready, may re-request back-to-back
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            si = if_ready; sm = mem_ready;
            drive_edge();
            if (if_req && si) if_req = 0;
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = 32'($urandom_range(0, 1023));
            end
            if ((mem_rd || mem_wr) && sm) begin mem_rd = 0; mem_wr = 0; end
            if (!(mem_rd || mem_wr) && $urandom_range(0, 2) == 0) begin
                k = int'($urandom_range(0, 7));
                mem_rd = (k < 4) || (k == 7);
                mem_wr = (k >= 4);
                mem_addr = 32'($urandom_range(0, 1023));
                mem_wdata = $urandom;
            end
        end
        drive_edge(); if_req = 0; mem_rd = 0; mem_wr = 0;
        repeat (12) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
